// File: rtl/decode_r32i.sv
// rtl/decode_r32i.sv - registered RV32I decode stage producing the ALU control bundle
module decode_r32i #(
  parameter int dataW = 32
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             flush,
  input  logic [dataW-1:0] instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       alucode,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [dataW-1:0] imm,
  output logic             use_imm,
  output logic             use_pc,
  output logic             reg_write,
  output logic             is_load,
  output logic             is_store,
  output logic             is_branch,
  output logic             is_jump,
  output logic [2:0]       funct3,
  output logic             illegal
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLT  = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SSL  = 4'd6;
  localparam logic [3:0] ALU_SSR  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_CPY  = 4'd9;
  localparam logic [3:0] ALU_SUB  = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]       alucode;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [dataW-1:0] imm;
    logic             use_imm;
    logic             use_pc;
    logic             reg_write;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_jump;
    logic [2:0]       funct3;
    logic             illegal;
  } bundle_t;

  bundle_t    dec;
  bundle_t    bundle_d, bundle_q;
  logic       out_valid_d, out_valid_q;
  logic       legal;
  logic       wants_rd;
  logic [6:0] opcode;
  logic [6:0] f7;
  logic [2:0] f3;

  logic [dataW-1:0] i_imm, s_imm, b_imm, u_imm, j_imm;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign i_imm = {{20{instr[31]}}, instr[31:20]};
  assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign u_imm = {instr[31:12], 12'b0};
  assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Shared f3 -> ALU mapping for the base (f7 = 0) register and immediate forms
  function automatic logic [3:0] base_alu(input logic [2:0] sel);
    logic [3:0] code;
    case (sel)
      3'b000:  code = ALU_ADD;
      3'b001:  code = ALU_SSL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = ALU_SSR;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  always_comb begin
    dec        = '0;
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = f3;
    legal      = 1'b1;
    wants_rd   = 1'b0;

    case (opcode)
      OPC_OP: begin
        wants_rd = 1'b1;
        if (f7 == F7_BASE) begin
          dec.alucode = base_alu(f3);
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec.alucode = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec.alucode = ALU_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        wants_rd    = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = i_imm;
        // Only shifts constrain imm[11:5]; other I-type ops use the full immediate
        if (f3 == 3'b001) begin
          dec.alucode = ALU_SSL;
          legal       = (f7 == F7_BASE);
        end else if (f3 == 3'b101) begin
          if (f7 == F7_BASE) begin
            dec.alucode = ALU_SSR;
          end else if (f7 == F7_ALT) begin
            dec.alucode = ALU_SRA;
          end else begin
            legal = 1'b0;
          end
        end else begin
          dec.alucode = base_alu(f3);
        end
      end
      OPC_LUI: begin
        wants_rd    = 1'b1;
        dec.alucode = ALU_CPY;
        dec.use_imm = 1'b1;
        dec.imm     = u_imm;
      end
      OPC_AUIPC: begin
        wants_rd    = 1'b1;
        dec.alucode = ALU_ADD;
        dec.use_imm = 1'b1;
        dec.use_pc  = 1'b1;
        dec.imm     = u_imm;
      end
      OPC_LOAD: begin
        wants_rd    = 1'b1;
        dec.alucode = ALU_ADD;
        dec.use_imm = 1'b1;
        dec.is_load = 1'b1;
        dec.imm     = i_imm;
      end
      OPC_STORE: begin
        dec.alucode  = ALU_ADD;
        dec.use_imm  = 1'b1;
        dec.is_store = 1'b1;
        dec.imm      = s_imm;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.imm       = b_imm;
        case (f3[2:1])
          2'b00:   dec.alucode = ALU_SUB;
          2'b10:   dec.alucode = ALU_SLT;
          2'b11:   dec.alucode = ALU_SLTU;
          default: legal       = 1'b0;
        endcase
      end
      OPC_JAL: begin
        wants_rd    = 1'b1;
        dec.alucode = ALU_ADD;
        dec.use_imm = 1'b1;
        dec.use_pc  = 1'b1;
        dec.is_jump = 1'b1;
        dec.imm     = j_imm;
      end
      OPC_JALR: begin
        wants_rd    = 1'b1;
        dec.alucode = ALU_ADD;
        dec.use_imm = 1'b1;
        dec.is_jump = 1'b1;
        dec.imm     = i_imm;
        legal       = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase

    // Illegal encodings keep the register/funct3 fields but drop all control
    if (!legal) begin
      dec.alucode   = ALU_ADD;
      dec.imm       = '0;
      dec.use_imm   = 1'b0;
      dec.use_pc    = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
      dec.illegal   = 1'b1;
    end
    dec.reg_write = wants_rd && legal && (dec.rd != 5'd0);
  end

  assign in_ready = nReset && !flush && (!out_valid_q || out_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid_d = 1'b1;
      bundle_d    = dec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!nReset) begin
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alucode   = bundle_q.alucode;
  assign rs1       = bundle_q.rs1;
  assign rs2       = bundle_q.rs2;
  assign rd        = bundle_q.rd;
  assign imm       = bundle_q.imm;
  assign use_imm   = bundle_q.use_imm;
  assign use_pc    = bundle_q.use_pc;
  assign reg_write = bundle_q.reg_write;
  assign is_load   = bundle_q.is_load;
  assign is_store  = bundle_q.is_store;
  assign is_branch = bundle_q.is_branch;
  assign is_jump   = bundle_q.is_jump;
  assign funct3    = bundle_q.funct3;
  assign illegal   = bundle_q.illegal;

endmodule

// File: tb/tb_decode_r32i.sv
// tb/tb_decode_r32i.sv - directed and randomized self-checking bench for decode_r32i
module tb_decode_r32i;

  typedef struct packed {
    logic [3:0]  alucode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        reg_write;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic [2:0]  funct3;
    logic        illegal;
  } bundle_t;

  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;
  localparam logic [31:0] I_SRAI = 32'h40335293;
  localparam logic [31:0] I_LUI  = 32'h12345137;

  logic        clock;
  logic        nReset;
  logic        flush;
  logic [31:0] instr;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alucode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        use_imm, use_pc, reg_write, is_load, is_store, is_branch, is_jump;
  logic [2:0]  funct3;
  logic        illegal;

  bundle_t dut_b;
  bundle_t mb;
  logic    mv;
  int      checks;
  int      failures;

  decode_r32i #(.dataW(32)) dut (
    .clock(clock), .nReset(nReset), .flush(flush), .instr(instr),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .alucode(alucode), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .use_imm(use_imm), .use_pc(use_pc), .reg_write(reg_write), .is_load(is_load),
    .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
    .funct3(funct3), .illegal(illegal)
  );

  assign dut_b = {alucode, rs1, rs2, rd, imm, use_imm, use_pc, reg_write,
                  is_load, is_store, is_branch, is_jump, funct3, illegal};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules, using arithmetic immediates
  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t     e;
    int          code;
    bit          rw;
    int          alu_of_f3 [8];
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
    alu_of_f3 = '{0, 6, 1, 2, 5, 7, 4, 3};
    f3 = w[14:12];
    f7 = w[31:25];
    i_imm = 32'($signed(w) >>> 20);
    s_imm = (i_imm & ~32'h1F) | 32'(w[11:7]);
    b_imm = (w[31] ? 32'hFFFFF000 : 32'h0) + (32'(w[7]) << 11) + (32'(w[30:25]) << 5) + (32'(w[11:8]) << 1);
    u_imm = w & 32'hFFFFF000;
    j_imm = (w[31] ? 32'hFFF00000 : 32'h0) + (32'(w[19:12]) << 12) + (32'(w[20]) << 11) + (32'(w[30:21]) << 1);
    e = '0;
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.rd = w[11:7];
    e.funct3 = f3;
    code = -1;
    rw = 0;
    case (w[6:0])
      7'h33: begin
        rw = 1;
        if (f7 == 7'h00) code = alu_of_f3[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) code = 10;
        else if (f7 == 7'h20 && f3 == 3'd5) code = 8;
      end
      7'h13: begin
        rw = 1; e.use_imm = 1; e.imm = i_imm;
        if (f3 == 3'd1) code = (f7 == 7'h00) ? 6 : -1;
        else if (f3 == 3'd5) code = (f7 == 7'h00) ? 7 : (f7 == 7'h20) ? 8 : -1;
        else code = alu_of_f3[f3];
      end
      7'h37: begin code = 9; rw = 1; e.use_imm = 1; e.imm = u_imm; end
      7'h17: begin code = 0; rw = 1; e.use_imm = 1; e.use_pc = 1; e.imm = u_imm; end
      7'h03: begin code = 0; rw = 1; e.use_imm = 1; e.is_load = 1; e.imm = i_imm; end
      7'h23: begin code = 0; e.use_imm = 1; e.is_store = 1; e.imm = s_imm; end
      7'h63: begin
        e.is_branch = 1; e.imm = b_imm;
        if (f3 <= 3'd1) code = 10;
        else if (f3 == 3'd4 || f3 == 3'd5) code = 1;
        else if (f3 >= 3'd6) code = 2;
      end
      7'h6F: begin code = 0; rw = 1; e.use_imm = 1; e.use_pc = 1; e.is_jump = 1; e.imm = j_imm; end
      7'h67: begin
        rw = 1; e.use_imm = 1; e.is_jump = 1; e.imm = i_imm;
        code = (f3 == 3'd0) ? 0 : -1;
      end
      default: code = -1;
    endcase
    if (code < 0) begin
      e.alucode = 4'd0; e.imm = '0; e.use_imm = 0; e.use_pc = 0; e.is_load = 0;
      e.is_store = 0; e.is_branch = 0; e.is_jump = 0; e.reg_write = 0; e.illegal = 1;
    end else begin
      e.alucode = 4'(code);
      e.reg_write = rw && (e.rd != 5'd0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 10))
      0: w[6:0] = 7'h33;
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4: w[6:0] = 7'h03;
      5: w[6:0] = 7'h23;
      6: w[6:0] = 7'h63;
      7: w[6:0] = 7'h6F;
      8: w[6:0] = 7'h67;
      default: ;
    endcase
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h13) && $urandom_range(0, 3) != 0)
      w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    if (w[6:0] == 7'h67 && $urandom_range(0, 1) != 0)
      w[14:12] = 3'd0;
    return w;
  endfunction

  // One clock: check everything at the falling edge, advance the model, return just after the rising edge
  task automatic cycle();
    logic m_rdy;
    @(negedge clock);
    m_rdy = nReset && !flush && (!mv || out_ready);
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(mv));
    chk("alucode", 32'(dut_b.alucode), 32'(mb.alucode));
    chk("imm", dut_b.imm, mb.imm);
    chk("regs", 32'({dut_b.rs1, dut_b.rs2, dut_b.rd, dut_b.funct3}), 32'({mb.rs1, mb.rs2, mb.rd, mb.funct3}));
    chk("flags", 32'({dut_b.use_imm, dut_b.use_pc, dut_b.reg_write, dut_b.is_load, dut_b.is_store,
                      dut_b.is_branch, dut_b.is_jump, dut_b.illegal}),
                 32'({mb.use_imm, mb.use_pc, mb.reg_write, mb.is_load, mb.is_store,
                      mb.is_branch, mb.is_jump, mb.illegal}));
    if (!nReset) begin
      mv = 0; mb = '0;
    end else if (flush) begin
      mv = 0;
    end else if (in_valid && m_rdy) begin
      mv = 1; mb = ref_decode(instr);
    end else if (out_ready) begin
      mv = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic r, input logic f, input logic n);
    in_valid = v; instr = w; out_ready = r; flush = f; nReset = n;
    cycle();
  endtask

  initial begin
    checks = 0; failures = 0;
    mv = 0; mb = '0;
    nReset = 0; flush = 0; instr = '0; in_valid = 0; out_ready = 0;
    @(posedge clock);
    #1;

    drive(1, I_SUB, 1, 0, 0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alucode", 32'(alucode), 32'd0);
    chk("rst_imm", imm, 32'd0);

    drive(1, I_SUB, 1, 0, 1);
    chk("sub_valid", 32'(out_valid), 32'd1);
    chk("sub_alucode", 32'(alucode), 32'd10);
    chk("sub_regs", 32'({rs1, rs2, rd}), 32'({5'd10, 5'd11, 5'd10}));
    chk("sub_ctl", 32'({use_imm, reg_write}), 32'b01);

    drive(1, I_ADDI, 1, 0, 1);
    chk("addi_alucode", 32'(alucode), 32'd0);
    chk("addi_imm", imm, 32'hFFFFFFFF);
    chk("addi_ctl", 32'({use_imm, reg_write, rd}), 32'({1'b1, 1'b1, 5'd1}));

    drive(1, I_SRAI, 1, 0, 1);
    chk("srai_valid", 32'(out_valid), 32'd1);
    chk("srai_alucode", 32'(alucode), 32'd8);
    chk("srai_shamt", 32'(imm[4:0]), 32'd3);

    drive(1, I_LUI, 1, 0, 1);
    chk("lui_alucode", 32'(alucode), 32'd9);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_use_imm", 32'(use_imm), 32'd1);

    drive(1, 32'h0, 1, 0, 1);
    chk("zero_illegal", 32'(illegal), 32'd1);
    chk("zero_alucode", 32'(alucode), 32'd0);
    chk("zero_flags", 32'({use_imm, use_pc, reg_write, is_load, is_store, is_branch, is_jump}), 32'd0);

    drive(1, I_LUI, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, I_SUB, 0, 0, 1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_alucode", 32'(alucode), 32'd9);
      chk("stall_imm", imm, 32'h12345000);
    end
    drive(1, I_ADDI, 1, 0, 1);
    chk("release_valid", 32'(out_valid), 32'd1);
    chk("release_alucode", 32'(alucode), 32'd0);
    chk("release_imm", imm, 32'hFFFFFFFF);

    drive(1, I_SUB, 1, 1, 1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_not_captured", 32'(alucode), 32'd0);
    drive(0, 32'h0, 1, 0, 1);
    chk("flush_idle_valid", 32'(out_valid), 32'd0);

    drive(1, I_SRAI, 1, 0, 1);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    drive(1, I_SUB, 1, 0, 0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_alucode", 32'(alucode), 32'd0);

    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 9) < 7, rand_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_r32i.md
# decode_r32i

Registered RV32I instruction decode stage that produces the ALU control word (alucode, operand selects, immediate) consumed by the RV32I ALU, plus register indices and class flags for the rest of the datapath. Accepts one 32-bit instruction per cycle over a valid/ready handshake and presents the decoded bundle one cycle later from a single-entry output register with backpressure and flush.

## Interface
- dataW, 32: instruction and immediate width.
- clock  input  1  rising-edge clock.
- nReset  input  1  synchronous, active-low reset.
- flush  input  1  discard the held output and refuse input this cycle.
- instr  input  dataW  instruction word.
- in_valid  input  1  instr valid.
- in_ready  output  1  stage can accept instr.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts bundle.
- alucode  output  4  ADD=0, SLT=1, SLTU=2, AND=3, OR=4, XOR=5, SSL=6, SSR=7, SRA=8, CPY=9, SUB=10 (values from alucodesR32I.sv).
- rs1, rs2, rd  output  5 each  instr[19:15], [24:20], [11:7].
- imm  output  dataW  sign-extended immediate for the instruction format.
- use_imm  output  1  ALU B = imm, else rs2 data.
- use_pc  output  1  ALU A = PC, else rs1 data.
- reg_write, is_load, is_store, is_branch, is_jump  output  1 each  class flags.
- funct3  output  3  instr[14:12], passed through for branch/memory width.
- illegal  output  1  unrecognised encoding.

## Operation
- Opcode (instr[6:0]) decode:
  - OP 0110011: f7=0000000: f3 000 ADD, 001 SSL, 010 SLT, 011 SLTU, 100 XOR, 101 SSR, 110 OR, 111 AND. f7=0100000: f3 000 SUB, 101 SRA. Any other f3/f7 pairing is illegal. reg_write=1.
  - OP-IMM 0010011: as OP with use_imm=1, I-imm; no SUB. Shifts: imm[11:5] must be 0000000 (SSL/SSR) or 0100000 (SRA only, f3=101), else illegal.
  - LUI 0110111: CPY, U-imm, use_imm, reg_write.
  - AUIPC 0010111: ADD, U-imm, use_pc, use_imm, reg_write.
  - LOAD 0000011: ADD, I-imm, use_imm, is_load, reg_write.
  - STORE 0100011: ADD, S-imm, use_imm, is_store.
  - BRANCH 1100011: f3 000/001 SUB, 100/101 SLT, 110/111 SLTU; 010/011 illegal; B-imm, use_imm=0, is_branch.
  - JAL 1101111: ADD, J-imm, use_pc, use_imm, is_jump, reg_write.
  - JALR 1100111: f3 must be 000; ADD, I-imm, use_imm, is_jump, reg_write.
- Immediates sign-extend from instr[31]; U-imm = {instr[31:12], 12'b0}; B/J imm bit 0 = 0.
- reg_write forced 0 when rd = 0.
- Illegal: illegal=1, alucode=ADD, all class flags and use_* = 0; bundle still delivered via handshake.

## Timing
- in_ready = !flush && (!out_valid || out_ready), combinational.
- Transfer on in_valid && in_ready; bundle registered, out_valid=1 next cycle. Latency 1, throughput 1/cycle with out_ready held high.
- out_valid && !out_ready: every output holds stable; no input accepted.
- Simultaneous output consume and input accept: new bundle replaces old with no bubble.
- flush: out_valid=0 next cycle; in_ready=0 that cycle, so no instruction is captured; flush wins over everything except reset.
- Reset (nReset=0 at clock edge), including mid-transfer: out_valid=0, alucode=ADD, all other outputs 0. in_ready is 0 while nReset=0.
- Outputs other than out_valid are don't-care while out_valid=0, but the implementation holds them at the last value.

## Test plan
- 0x40B50533 (sub x10,x10,x11), out_ready=1 -> next cycle out_valid=1, alucode=10, rs1=10, rs2=11, rd=10, use_imm=0, reg_write=1.
- 0xFFF00093 (addi x1,x0,-1) -> alucode=0, imm=0xFFFFFFFF, use_imm=1, rd=1, reg_write=1; 0x40335293 (srai x5,x6,3) back-to-back -> alucode=8, imm[4:0]=3, no bubble between bundles.
- 0x12345137 (lui x2) -> alucode=9, imm=0x12345000, use_imm=1; 0x00000000 -> illegal=1, alucode=0, all flags 0.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; out_ready=1 -> held bundle consumed and the next instruction is captured in the same cycle.
- flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, pending instr not captured; nReset low mid-stream -> out_valid=0, alucode=0 next edge.
